// File: rtl/aes_pkg.sv
// Shared AES tables and byte-addressing helpers.
// State byte i (FIPS-197 order, column-major) lives in bits [127-8i -: 8].
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Index 0 is unused so that RCON[r] is the constant for round r.
    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic int unsigned byte_idx(int unsigned r, int unsigned c);
        return r + 4 * c;
    endfunction

    function automatic logic [6:0] byte_lsb(int unsigned idx);
        return 7'(120 - 8 * idx);
    endfunction

    function automatic logic [7:0] get_byte(aes_state_t s, int unsigned idx);
        return s[byte_lsb(idx) +: 8];
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless last is set, InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  aes_state_t state,
    input  aes_state_t round_key,
    input  logic       last,
    output aes_state_t next_state
);

    // Constant multiply by c in GF(2^8) built from xtime chains (c in {09,0b,0d,0e}).
    function automatic logic [7:0] gmul(logic [7:0] b, logic [3:0] c);
        logic [7:0] x2, x4, x8, acc;
        x2  = xtime(b);
        x4  = xtime(x2);
        x8  = xtime(x4);
        acc = 8'h00;
        if (c[0]) acc = acc ^ b;
        if (c[1]) acc = acc ^ x2;
        if (c[2]) acc = acc ^ x4;
        if (c[3]) acc = acc ^ x8;
        return acc;
    endfunction

    aes_state_t shifted, subbed, keyed, mixed;

    always_comb begin
        shifted = '0;
        subbed  = '0;
        mixed   = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                shifted[byte_lsb(byte_idx(r, c)) +: 8] =
                    get_byte(state, byte_idx(r, (c + 4 - r) % 4));
            end
        end
        for (int unsigned i = 0; i < 16; i++) begin
            subbed[byte_lsb(i) +: 8] = INV_SBOX[get_byte(shifted, i)];
        end
        keyed = subbed ^ round_key;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                mixed[byte_lsb(byte_idx(r, c)) +: 8] =
                    gmul(get_byte(keyed, byte_idx(r, c)), 4'he) ^
                    gmul(get_byte(keyed, byte_idx((r + 1) % 4, c)), 4'hb) ^
                    gmul(get_byte(keyed, byte_idx((r + 2) % 4, c)), 4'hd) ^
                    gmul(get_byte(keyed, byte_idx((r + 3) % 4, c)), 4'h9);
            end
        end
        next_state = last ? keyed : mixed;
    end

endmodule

// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, round keys walked backward
// from the last round key supplied with the ciphertext.
module aes_128_dec_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    if (NR != 10) begin : g_nr_check
        $fatal(1, "aes_128_dec_iter: NR must be 10");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Undo one forward key-expansion step: recover round key r-1 from round key r.
    function automatic aes_state_t inv_key_step(aes_state_t k, logic [7:0] rc);
        aes_word_t w0, w1, w2, w3, rot;
        w0  = k[127:96];
        w1  = k[95:64];
        w2  = k[63:32];
        w3  = k[31:0];
        w3  = w3 ^ w2;
        w2  = w2 ^ w1;
        w1  = w1 ^ w0;
        rot = {w3[23:0], w3[31:24]};
        w0  = w0 ^ {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
                 ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    logic [1:0]  fsm;
    logic [3:0]  rnd;
    aes_state_t  state_reg, key_reg, round_out;
    logic        last_round;

    assign last_round = (rnd == 4'd0);

    aes_inv_round u_inv_round (
        .state      (state_reg),
        .round_key  (key_reg),
        .last       (last_round),
        .next_state (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            rnd       <= 4'd0;
            state_reg <= '0;
            key_reg   <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= in_data ^ in_key;
                        key_reg   <= inv_key_step(in_key, RCON[10]);
                        rnd       <= 4'd9;
                        fsm       <= BUSY;
                    end
                end
                BUSY: begin
                    state_reg <= round_out;
                    if (last_round) begin
                        fsm <= DONE;
                    end else begin
                        key_reg <= inv_key_step(key_reg, RCON[rnd]);
                        rnd     <= rnd - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign out_data  = state_reg;

endmodule

// File: tb/tb_aes_128_dec_iter.sv
// Bench for aes_128_dec_iter: a plain AES-128 encryptor (S-box derived from GF(2^8)
// inversion) produces ciphertext/last-round-key pairs; a monitor checks every output cycle.
module tb_aes_128_dec_iter;

    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] LRK_A = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] LRK_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam int           NRAND = 1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_data, in_key, out_data;

    int           checks = 0;
    int           failures = 0;
    int           n_out = 0;
    logic [7:0]   sb [256];
    logic [127:0] drv_exp;
    bit           b2b_mode = 1'b0;

    aes_128_dec_iter #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic aes_encrypt(input logic [127:0] pt, input logic [127:0] key,
                               output logic [127:0] ct, output logic [127:0] lrk);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [7:0]  a [16];
        logic [7:0]  b [16];
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gf_mul(8'h02, rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int i = 0; i < 16; i++) a[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
        for (int r10 = 1; r10 <= 10; r10++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) b[r + 4 * c] = sb[a[r + 4 * ((c + r) % 4)]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    a[r + 4 * c] = (r10 == 10) ? b[r + 4 * c] :
                        gf_mul(8'h02, b[r + 4 * c]) ^ gf_mul(8'h03, b[(r + 1) % 4 + 4 * c])
                        ^ b[(r + 2) % 4 + 4 * c] ^ b[(r + 3) % 4 + 4 * c];
            for (int i = 0; i < 16; i++) a[i] = a[i] ^ w[4 * r10 + i / 4][31 - 8 * (i % 4) -: 8];
        end
        ct = '0;
        for (int i = 0; i < 16; i++) ct[127 - 8 * i -: 8] = a[i];
        lrk = {w[40], w[41], w[42], w[43]};
    endtask

    // Monitor: scoreboard of accepted blocks, checked on every negative clock edge.
    logic [127:0] exp_q [$];
    int           acc_q [$];
    initial begin
        logic         prev_ov, prev_or, have_last;
        logic [127:0] prev_data;
        int           edge_n, last_acc, acc;
        prev_ov = 1'b0; prev_or = 1'b0; have_last = 1'b0; prev_data = '0;
        edge_n = 0; last_acc = 0;
        #1;
        forever begin
            @(negedge clk or negedge rst_n);
            if (clk && !rst_n) begin
                #1;
                chk("async_reset out_valid", 128'(out_valid), 128'h0);
                chk("async_reset in_ready", 128'(in_ready), 128'h1);
            end else if (!clk) begin
                edge_n++;
                if (!rst_n) begin
                    chk("reset out_valid", 128'(out_valid), 128'h0);
                    chk("reset in_ready", 128'(in_ready), 128'h1);
                    exp_q.delete();
                    acc_q.delete();
                    prev_ov = 1'b0;
                    prev_or = 1'b0;
                    have_last = 1'b0;
                end else begin
                    chk("in_ready only when idle", 128'(in_ready), 128'(exp_q.size() == 0));
                    if (out_valid) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected out_valid", 128'(out_valid), 128'h0);
                        end else begin
                            if (!prev_ov) chk("latency", 128'(edge_n - acc_q[0]), 128'd10);
                            chk("out_data", out_data, exp_q[0]);
                            if (prev_ov && !prev_or) chk("hold stable", out_data, prev_data);
                            if (out_ready) begin
                                void'(exp_q.pop_front());
                                void'(acc_q.pop_front());
                                n_out++;
                            end
                        end
                    end else if (exp_q.size() != 0 && edge_n == acc_q[0] + 10) begin
                        chk("out_valid on time", 128'(out_valid), 128'h1);
                    end
                    if (in_valid && in_ready) begin
                        acc = edge_n + 1;
                        exp_q.push_back(drv_exp);
                        acc_q.push_back(acc);
                        if (b2b_mode && have_last) chk("accept spacing", 128'(acc - last_acc), 128'd12);
                        last_acc = acc;
                        have_last = b2b_mode;
                    end
                    prev_ov = out_valid;
                    prev_or = out_ready;
                    prev_data = out_data;
                end
            end
        end
    end

    task automatic present(input logic [127:0] ct, input logic [127:0] key,
                           input logic [127:0] exp);
        in_data  = ct;
        in_key   = key;
        drv_exp  = exp;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (rst_n && in_valid && in_ready) break;
            n++;
            if (n > 40) begin
                fail_now({name, " accept"});
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int target, input int budget);
        int n;
        n = 0;
        while (n_out < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n_out < target) fail_now("output count");
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] ct, lrk, pt, key;
        int           n;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b1;
        drv_exp = '0;

        build_sbox();
        chk("model sbox[00]", 128'(sb[8'h00]), 128'h63);
        chk("model sbox[53]", 128'(sb[8'h53]), 128'hed);
        aes_encrypt(PT_A, KEY_A, ct, lrk);
        chk("model ct A", ct, CT_A);
        chk("model last key A", lrk, LRK_A);
        aes_encrypt(PT_B, KEY_B, ct, lrk);
        chk("model ct B", ct, CT_B);
        chk("model last key B", lrk, LRK_B);

        // First block offered together with reset release: accepted on the first edge.
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        present(CT_A, LRK_A, PT_A);
        wait_accept("vector A");
        in_valid = 1'b0;
        wait_out(1, 40);

        // Backpressure: result held 20 cycles while a second block waits.
        out_ready = 1'b0;
        present(CT_A, LRK_A, PT_A);
        wait_accept("bp first");
        present(CT_B, LRK_B, PT_B);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        if (!out_valid) fail_now("bp out_valid");
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept("bp second");
        in_valid = 1'b0;
        wait_out(3, 60);

        // Reset pulse while rnd is 5; the aborted block must never appear.
        present(CT_B, LRK_B, PT_B);
        wait_accept("abort");
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        present(CT_A, LRK_A, PT_A);
        wait_accept("after reset");
        in_valid = 1'b0;
        wait_out(4, 40);

        // Back-to-back with in_valid held high, then random round trips.
        b2b_mode = 1'b1;
        present(CT_A, LRK_A, PT_A);
        wait_accept("b2b A");
        present(CT_B, LRK_B, PT_B);
        wait_accept("b2b B");
        for (int i = 0; i < NRAND; i++) begin
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            aes_encrypt(pt, key, ct, lrk);
            present(ct, lrk, pt);
            wait_accept("random");
        end
        in_valid = 1'b0;
        wait_out(4 + 2 + NRAND, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
